// File: rtl/umtrx_vita_rx_framer.sv
// -----------------------------------------------------------------------------
// umtrx_vita_rx_framer
//   Packs strobed DDC samples into VITA-style RX packets. A write side fills a
//   sample FIFO and hands each finished packet's {timestamp, length} to a
//   one-entry commit slot. A read side then emits HDR, SID, TSH, TSL and the N
//   data words on a 36-bit source-ready/destination-ready stream.
//
// Ports
//   clk, reset            : sole clock, synchronous active-high reset
//   set_stb/addr/data     : settings bus (BASE+0 SID, BASE+1 N, BASE+2 bit0 en)
//   vita_time             : current VITA time, latched at each packet's 1st sample
//   sample, strobe        : I/Q sample and its one-cycle valid
//   rx_data_o             : [33]=EOF, [32]=SOF, [31:0]=packet word
//   rx_src_rdy_o/dst_rdy_i: stream handshake, a word moves when both are high
//   overflow              : one-cycle pulse per dropped packet
//   run                   : enable register bit
// -----------------------------------------------------------------------------
module umtrx_vita_rx_framer #(
  parameter int BASE     = 0,
  parameter int FIFOSIZE = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] vita_time,
  input  logic [31:0] sample,
  input  logic        strobe,
  output logic [35:0] rx_data_o,
  output logic        rx_src_rdy_o,
  input  logic        rx_dst_rdy_i,
  output logic        overflow,
  output logic        run
);

  localparam int DEPTH = 1 << FIFOSIZE;
  localparam int PW    = FIFOSIZE + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SID, S_TSH, S_TSL, S_DATA} state_t;

  // ---------------- settings registers ----------------
  logic [31:0] sid_q;
  logic [15:0] nsamp_q;
  logic        enable_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sid_q    <= 32'd0;
      nsamp_q  <= 16'd0;
      enable_q <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))     sid_q    <= set_data;
      if (set_addr == 8'(BASE + 1)) nsamp_q  <= set_data[15:0];
      if (set_addr == 8'(BASE + 2)) enable_q <= set_data[0];
    end
  end

  assign run = enable_q;

  // Packet length clamped to 1..DEPTH so a whole packet always fits the FIFO.
  logic [15:0] n_eff;
  always_comb begin
    n_eff = nsamp_q;
    if (nsamp_q == 16'd0)
      n_eff = 16'd1;
    else if ({1'b0, nsamp_q} > 17'(DEPTH))
      n_eff = 16'(DEPTH);
  end

  // ---------------- sample FIFO ----------------
  // Pointers carry one extra wrap bit; cmt_ptr_q marks the end of committed data.
  logic [31:0]   mem [DEPTH];
  logic [31:0]   mem_rd_q;
  logic [PW-1:0] wr_ptr_q, cmt_ptr_q, rd_ptr_q, rd_ptr_d;
  logic          pop, take, fifo_full;

  // A pop in the same cycle frees a slot, so a write at full still succeeds.
  assign fifo_full = (wr_ptr_q[FIFOSIZE] != rd_ptr_q[FIFOSIZE]) &&
                     (wr_ptr_q[FIFOSIZE-1:0] == rd_ptr_q[FIFOSIZE-1:0]) && !pop;

  // ---------------- write side ----------------
  logic [15:0] wcnt_q, pkt_n_q, slot_n_q, wr_n;
  logic [63:0] pkt_ts_q, slot_ts_q;
  logic        slot_valid_q, overflow_q;
  logic        wr_first, wr_last, wr_drop, wr_en;

  assign wr_first = (wcnt_q == 16'd0);
  assign wr_n     = wr_first ? n_eff : pkt_n_q;
  assign wr_last  = ((wcnt_q + 16'd1) == wr_n);
  // The slot counts as free if the read side is taking it this very cycle.
  assign wr_drop  = enable_q && strobe &&
                    (fifo_full || (wr_last && slot_valid_q && !take));
  assign wr_en    = enable_q && strobe && !wr_drop;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      cmt_ptr_q    <= '0;
      wcnt_q       <= 16'd0;
      pkt_n_q      <= 16'd1;
      pkt_ts_q     <= 64'd0;
      slot_valid_q <= 1'b0;
      slot_ts_q    <= 64'd0;
      slot_n_q     <= 16'd1;
      overflow_q   <= 1'b0;
    end else begin
      overflow_q <= wr_drop;
      if (take) slot_valid_q <= 1'b0;
      if (!enable_q || wr_drop) begin
        // Discard the partial packet; the next accepted strobe starts afresh.
        wr_ptr_q <= cmt_ptr_q;
        wcnt_q   <= 16'd0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (wr_first) begin
          pkt_ts_q <= vita_time;
          pkt_n_q  <= n_eff;
        end
        if (wr_last) begin
          wcnt_q       <= 16'd0;
          cmt_ptr_q    <= wr_ptr_q + PW'(1);
          slot_valid_q <= 1'b1;
          slot_ts_q    <= wr_first ? vita_time : pkt_ts_q;
          slot_n_q     <= wr_n;
        end else begin
          wcnt_q <= wcnt_q + 16'd1;
        end
      end
    end
  end

  // Registered read of the word the read side will present next cycle; the
  // addressed entry is never overwritten while it is still unread.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[FIFOSIZE-1:0]] <= sample;
    mem_rd_q <= mem[rd_ptr_d[FIFOSIZE-1:0]];
  end

  // ---------------- read side ----------------
  state_t      state_q, state_d;
  logic [15:0] rd_cnt_q, rd_n_q;
  logic [63:0] rd_ts_q;
  logic [31:0] rd_sid_q;
  logic [3:0]  pkt_cnt_q;
  logic        rd_last;

  assign rd_last = (rd_cnt_q == (rd_n_q - 16'd1));

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    pop          = 1'b0;
    take         = 1'b0;
    rx_src_rdy_o = 1'b0;
    rx_data_o    = 36'd0;
    case (state_q)
      S_IDLE: begin
        if (slot_valid_q) begin
          take    = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        rx_src_rdy_o = 1'b1;
        rx_data_o    = {2'b00, 1'b0, 1'b1, 4'h1, 6'd0, 2'b01, pkt_cnt_q, rd_n_q + 16'd4};
        if (rx_dst_rdy_i) state_d = S_SID;
      end
      S_SID: begin
        rx_src_rdy_o = 1'b1;
        rx_data_o    = {4'h0, rd_sid_q};
        if (rx_dst_rdy_i) state_d = S_TSH;
      end
      S_TSH: begin
        rx_src_rdy_o = 1'b1;
        rx_data_o    = {4'h0, rd_ts_q[63:32]};
        if (rx_dst_rdy_i) state_d = S_TSL;
      end
      S_TSL: begin
        rx_src_rdy_o = 1'b1;
        rx_data_o    = {4'h0, rd_ts_q[31:0]};
        if (rx_dst_rdy_i) state_d = S_DATA;
      end
      S_DATA: begin
        rx_src_rdy_o = (rd_ptr_q != cmt_ptr_q);
        rx_data_o    = {2'b00, rd_last, 1'b0, mem_rd_q};
        if (rx_src_rdy_o && rx_dst_rdy_i) begin
          pop      = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      rd_cnt_q  <= 16'd0;
      rd_n_q    <= 16'd1;
      rd_ts_q   <= 64'd0;
      rd_sid_q  <= 32'd0;
      pkt_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      if (take) begin
        rd_n_q   <= slot_n_q;
        rd_ts_q  <= slot_ts_q;
        rd_sid_q <= sid_q;
        rd_cnt_q <= 16'd0;
      end
      if (pop) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
        if (rd_last) pkt_cnt_q <= pkt_cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_umtrx_vita_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_umtrx_vita_rx_framer
//   Directed bench for umtrx_vita_rx_framer (BASE=16, FIFOSIZE=4). Inputs are
//   driven on the falling edge; every word the DUT hands over is logged, as is
//   the time/value of every strobe driven, and packets are compared against
//   hand-written header constants and the logged stimulus.
// -----------------------------------------------------------------------------
module tb_umtrx_vita_rx_framer;
  localparam int BASE_ADDR = 16;
  localparam logic [63:0] VT0 = 64'h0000_00A5_1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] vita_time;
  logic [31:0] sample;
  logic        strobe;
  logic [35:0] rx_data_o;
  logic        rx_src_rdy_o;
  logic        rx_dst_rdy_i;
  logic        overflow;
  logic        run;

  always #5 clk = ~clk;

  umtrx_vita_rx_framer #(.BASE(BASE_ADDR), .FIFOSIZE(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .set_stb      (set_stb),
    .set_addr     (set_addr),
    .set_data     (set_data),
    .vita_time    (vita_time),
    .sample       (sample),
    .strobe       (strobe),
    .rx_data_o    (rx_data_o),
    .rx_src_rdy_o (rx_src_rdy_o),
    .rx_dst_rdy_i (rx_dst_rdy_i),
    .overflow     (overflow),
    .run          (run)
  );

  int          nerr = 0;
  int          nchk = 0;
  int          cyc = 0;
  int          period = 0;
  int          stb_left = 0;
  int          ovf_cnt = 0;
  logic [31:0] smp = 32'h5000_0000;
  logic [35:0] outq[$];
  logic [63:0] stb_vt[$];
  logic [31:0] stb_smp[$];

  task automatic chkw(input string tag, input logic [35:0] got, input logic [35:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: log the word the next rising edge transfers,
  // drive the next strobe/time, then move to the following falling edge.
  task automatic tick();
    if (rx_src_rdy_o === 1'b1 && rx_dst_rdy_i) outq.push_back(rx_data_o);
    cyc++;
    vita_time = VT0 + 64'(cyc);
    if (period != 0 && stb_left > 0 && (cyc % period) == 0) begin
      strobe = 1'b1;
      sample = smp;
      stb_vt.push_back(vita_time);
      stb_smp.push_back(smp);
      smp++;
      stb_left--;
    end else begin
      strobe = 1'b0;
    end
    @(negedge clk);
    if (overflow === 1'b1) ovf_cnt++;
  endtask

  task automatic run_n(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_set(input int off, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = 8'(BASE_ADDR + off);
    set_data = d;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic clear_logs();
    outq.delete();
    stb_vt.delete();
    stb_smp.delete();
    ovf_cnt = 0;
  endtask

  initial begin
    int guard;
    int nsave;
    int neof;
    int lat;

    reset = 1'b1; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
    vita_time = VT0; sample = 32'd0; strobe = 1'b0; rx_dst_rdy_i = 1'b1;

    // Reset state
    run_n(3);
    chki("rst_src_rdy", int'(rx_src_rdy_o), 0);
    chkw("rst_data", rx_data_o, 36'd0);
    chki("rst_ovf", int'(overflow), 0);
    chki("rst_run", int'(run), 0);
    reset = 1'b0;
    run_n(2);

    // N=4, strobe every 3rd cycle: two 8-word packets
    wr_set(0, 32'hABCD_0001);
    wr_set(1, 32'd4);
    wr_set(2, 32'd1);
    chki("run_en", int'(run), 1);
    clear_logs();
    period = 3; stb_left = 8;
    run_n(60);
    chki("s1_words", outq.size(), 16);
    chkw("s1_hdr0", outq[0], 36'h1_1010_0008);
    chkw("s1_sid", outq[1], 36'h0_ABCD_0001);
    chkw("s1_tsh", outq[2], {4'h0, stb_vt[0][63:32]});
    chkw("s1_tsl", outq[3], {4'h0, stb_vt[0][31:0]});
    chkw("s1_d0", outq[4], {4'h0, stb_smp[0]});
    chkw("s1_eof", outq[7], {4'h2, stb_smp[3]});
    chkw("s1_hdr1", outq[8], 36'h1_1011_0008);
    chkw("s1_tsl1", outq[11], {4'h0, stb_vt[4][31:0]});
    chkw("s1_eof1", outq[15], {4'h2, stb_smp[7]});
    chki("s1_ovf", ovf_cnt, 0);

    // Enable dropped after 2 strobes: those samples vanish, count unchanged
    clear_logs();
    period = 1; stb_left = 2;
    run_n(5);
    wr_set(2, 32'd0);
    chki("s2_run_off", int'(run), 0);
    run_n(3);
    wr_set(2, 32'd1);
    stb_left = 4;
    run_n(30);
    chki("s2_words", outq.size(), 8);
    chkw("s2_hdr", outq[0], 36'h1_1012_0008);
    chkw("s2_tsh", outq[2], {4'h0, stb_vt[2][63:32]});
    chkw("s2_tsl", outq[3], {4'h0, stb_vt[2][31:0]});
    chkw("s2_d0", outq[4], {4'h0, stb_smp[2]});
    chkw("s2_eof", outq[7], {4'h2, stb_smp[5]});
    chki("s2_ovf", ovf_cnt, 0);

    // N=0 behaves as N=1: 5-word packets, SOF and EOF on distinct words
    wr_set(1, 32'd0);
    clear_logs();
    period = 2; stb_left = 2;
    run_n(20);
    chki("s3_words", outq.size(), 10);
    chkw("s3_hdr0", outq[0], 36'h1_1013_0005);
    chkw("s3_eof0", outq[4], {4'h2, stb_smp[0]});
    chkw("s3_hdr1", outq[5], 36'h1_1014_0005);
    chkw("s3_eof1", outq[9], {4'h2, stb_smp[1]});

    // FIFOSIZE=4, N=16, sink stalled: one packet commits, the rest overflow
    wr_set(1, 32'd16);
    clear_logs();
    rx_dst_rdy_i = 1'b0;
    period = 1; stb_left = 40;
    run_n(200);
    chki("s4_ovf", ovf_cnt, 24);
    chki("s4_stall_words", outq.size(), 0);
    chki("s4_stall_rdy", int'(rx_src_rdy_o), 1);
    chkw("s4_stall_hold", rx_data_o, 36'h1_1015_0014);
    rx_dst_rdy_i = 1'b1;
    run_n(40);
    chki("s4_words_a", outq.size(), 20);
    chkw("s4_hdr_a", outq[0], 36'h1_1015_0014);
    chkw("s4_tsl_a", outq[3], {4'h0, stb_vt[0][31:0]});
    chkw("s4_eof_a", outq[19], {4'h2, stb_smp[15]});
    stb_left = 16;
    run_n(50);
    chki("s4_words_b", outq.size(), 40);
    chkw("s4_hdr_b", outq[20], 36'h1_1016_0014);
    chkw("s4_tsh_b", outq[22], {4'h0, stb_vt[40][63:32]});
    chkw("s4_tsl_b", outq[23], {4'h0, stb_vt[40][31:0]});
    chkw("s4_d0_b", outq[24], {4'h0, stb_smp[40]});
    chkw("s4_eof_b", outq[39], {4'h2, stb_smp[55]});
    chki("s4_ovf_after", ovf_cnt, 24);

    // N above FIFO depth clamps to 16
    wr_set(1, 32'd100);
    clear_logs();
    period = 1; stb_left = 16;
    run_n(50);
    chki("s5_words", outq.size(), 20);
    chkw("s5_hdr", outq[0], 36'h1_1017_0014);
    chkw("s5_eof", outq[19], {4'h2, stb_smp[15]});

    // Packet counter wrap: counts 8..15 then 0
    wr_set(1, 32'd1);
    clear_logs();
    period = 6; stb_left = 9;
    run_n(70);
    chki("s6_words", outq.size(), 45);
    chkw("s6_hdr_f", outq[35], 36'h1_101F_0005);
    chkw("s6_hdr_0", outq[40], 36'h1_1010_0005);
    chkw("s6_eof", outq[44], {4'h2, stb_smp[8]});

    // Reset in the middle of DATA: no tail words, no EOF
    wr_set(1, 32'd16);
    clear_logs();
    period = 1; stb_left = 16;
    guard = 0;
    while (outq.size() < 6 && guard < 100) begin
      tick();
      guard++;
    end
    chki("s7_reach_data", int'(guard < 100), 1);
    reset = 1'b1;
    tick();
    nsave = outq.size();
    chki("s7_rst_src_rdy", int'(rx_src_rdy_o), 0);
    chki("s7_rst_run", int'(run), 0);
    reset = 1'b0;
    run_n(30);
    chki("s7_no_tail", outq.size(), nsave);
    neof = 0;
    for (int i = 0; i < outq.size(); i++) if (outq[i][33]) neof++;
    chki("s7_no_eof", neof, 0);

    // Post-reset defaults (SID=0, N=1, count=0) and commit-to-HDR latency
    wr_set(2, 32'd1);
    clear_logs();
    period = 1; stb_left = 1;
    tick();
    lat = 0;
    while (rx_src_rdy_o !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chki("s8_hdr_latency_ok", int'(lat <= 2), 1);
    chkw("s8_hdr", rx_data_o, 36'h1_1010_0005);
    run_n(10);
    chki("s8_words", outq.size(), 5);
    chkw("s8_sid", outq[1], 36'h0_0000_0000);
    chkw("s8_eof", outq[4], {4'h2, stb_smp[0]});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/umtrx_vita_rx_framer.md
UMTRX_VITA_RX_FRAMER -- requirements
Module: umtrx_vita_rx_framer

Interface
REQ-001 SHALL have parameter BASE, default 0, settings-bus base address.
REQ-002 SHALL have parameter FIFOSIZE, default 9, log2 depth of the sample FIFO in 32-bit words; legal range 4..15.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports set_stb  input  1, set_addr  input  8, set_data  input  32, forming the settings bus.
REQ-006 SHALL have port vita_time  input  64  current VITA time.
REQ-007 SHALL have port sample  input  32  I[31:16]/Q[15:0] DDC sample.
REQ-008 SHALL have port strobe  input  1  sample valid, one cycle per sample.
REQ-009 SHALL have port rx_data_o  output  36  [32]=SOF, [33]=EOF, [35:34]=0, [31:0]=packet word.
REQ-010 SHALL have ports rx_src_rdy_o  output  1 and rx_dst_rdy_i  input  1; a word transfers when both are high.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse per dropped packet.
REQ-012 SHALL have port run  output  1  equal to the enable register bit.

Function
REQ-013 SHALL decode registers BASE+0 = stream ID (32b), BASE+1 = samples per packet N (16b), BASE+2 bit0 = enable; writes take effect the cycle after set_stb.
REQ-014 SHALL treat N=0 as 1 and N>2^FIFOSIZE as 2^FIFOSIZE; effective N is latched at packet start.
REQ-015 Write side SHALL store each strobed sample while enable=1 into the FIFO at wr_ptr; the first sample of a packet latches vita_time from the same cycle.
REQ-016 On the N-th sample, write side SHALL commit: copy {timestamp, N} into a one-entry commit slot and set committed pointer = wr_ptr+1.
REQ-017 If a sample arrives with FIFO full, or the N-th sample arrives with the commit slot occupied, write side SHALL drop the sample, roll wr_ptr back to the committed pointer, pulse overflow, and restart the packet at the next strobe.
REQ-018 Deassertion of enable mid-packet SHALL roll wr_ptr back to the committed pointer without an overflow pulse.
REQ-019 Read side SHALL be a state machine IDLE -> HDR -> SID -> TSH -> TSL -> DATA -> IDLE; it leaves IDLE only when the commit slot is valid, and it frees the slot on entering HDR.
REQ-020 HDR word SHALL be [31:28]=4'h1, [27:22]=0, [21:20]=2'b01, [19:16]=packet count, [15:0]=N+4; SOF=1.
REQ-021 SID, TSH and TSL SHALL carry the stream ID latched at HDR, timestamp[63:32] and timestamp[31:0].
REQ-022 DATA SHALL emit exactly N FIFO words, with EOF on the last; the packet count (4b, wraps 15->0) SHALL increment on the EOF transfer.
REQ-023 rx_src_rdy_o SHALL be high in HDR/SID/TSH/TSL and in DATA while committed data is available; it SHALL be low in IDLE.
REQ-024 The state and the word SHALL advance only on transfer, with rx_data_o stable while rx_src_rdy_o=1 and rx_dst_rdy_i=0.
REQ-025 Latency from the commit cycle to HDR valid SHALL be at most 2 cycles when the read side is idle.
REQ-026 A FIFO write and read in the same cycle SHALL both succeed, including at full.
REQ-027 A packet already started on the read side SHALL complete regardless of enable, overflow or settings writes.

Reset
REQ-028 On reset, read state SHALL go to IDLE and pointers, commit slot and packet count SHALL clear.
REQ-029 On reset, rx_src_rdy_o=0, rx_data_o=0 and overflow=0.
REQ-030 On reset, stream ID=0, N=0 (effective 1) and enable=0, so run=0.
REQ-031 Reset asserted mid-packet SHALL abort it; no tail words SHALL appear after reset.

Verification
REQ-032 N=4, SID=0xABCD0001, enable, strobe every 3rd cycle, dst_rdy=1 -> 8-word packets; first HDR 0x10100008 with SOF, second 0x10110008; TSH/TSL equal vita_time at each packet's first strobe; EOF on word 8.
REQ-033 FIFOSIZE=4, N=16, dst_rdy=0 for 200 cycles, strobe every cycle -> first packet committed, then overflow pulses; after release the packets are contiguous in count and the timestamps match their first samples.
REQ-034 N=4, enable dropped after 2 strobes, re-enabled -> no packet contains those 2 samples, no overflow, next packet count unchanged.
REQ-035 N=0 -> 5-word packets with HDR[15:0]=5 and SOF and EOF on distinct words.
REQ-036 17 packets -> 16th HDR[19:16]=0xF, 17th 0x0.
REQ-037 Reset during DATA with dst_rdy=1 -> next cycle rx_src_rdy_o=0 and run=0; no EOF word emitted.
